// File: rtl/image_io_pkg.sv
`default_nettype none
// ============================================================================
// Module      : image_io_pkg
// Description : Shared types and constants for the image UART transmitter.
//               Holds the state encoding, the image size, and the UART
//               frame-length constants.
// Macro       : TX_PARITY_EN - adds an even-parity bit to each UART frame,
//               making an 11-bit frame instead of 10.
// Revision    : 1.0 - initial release
// ============================================================================
package image_io_pkg;

  // Bytes in one image frame (28 x 28 grey-scale).
  localparam int IMAGE_BYTES    = 784;

  localparam int UART_DATA_BITS = 8;
`ifdef TX_PARITY_EN
  localparam int UART_PARITY_BITS = 1;
`else
  localparam int UART_PARITY_BITS = 0;
`endif
  // Bit periods per character: start + data + optional parity + stop.
  localparam int UART_FRAME_BITS = 1 + UART_DATA_BITS + UART_PARITY_BITS + 1;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_FETCH      = 3'd1,
    ST_WAIT_DATA  = 3'd2,
    ST_START_BIT  = 3'd3,
    ST_DATA_BITS  = 3'd4,
    ST_PARITY_BIT = 3'd5,
    ST_STOP_BIT   = 3'd6,
    ST_FINISH     = 3'd7
  } state_e;

endpackage
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_serializer
// Description : Serializes one byte onto a UART line: start bit, 8 data bits
//               LSB first, optional even-parity bit, stop bit. Every bit lasts
//               exactly CLKS_PER_BIT clock cycles.
// Ports       : clk      - clock, rising edge
//               reset    - asynchronous active-high reset
//               load_i   - accept byte_i (honoured only while ready_o = 1)
//               byte_i   - byte to send
//               ready_o  - serializer idle, can take a new byte
//               sent_o   - high during the final cycle of the stop bit
//               tx_o     - serial line, idle high
// Macro       : TX_PARITY_EN - enables the parity bit.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_serializer
  import image_io_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_i,
  input  logic [7:0] byte_i,
  output logic       ready_o,
  output logic       sent_o,
  output logic       tx_o
);

  // A one-cycle bit still needs a 1-bit counter to keep the vectors legal.
  localparam int              CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             w_bit_end;
`ifdef TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  assign w_bit_end = (bit_cnt_q == BIT_LAST);

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
`ifdef TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
`ifdef TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = '0;
    idx_d     = idx_q;
    shift_d   = shift_q;
`ifdef TX_PARITY_EN
    parity_d  = parity_q;
`endif
    // The bit-period counter free-runs in every bit state and wraps at the
    // end of each bit, so all bit states share one timing source.
    if (state_q != ST_IDLE) begin
      bit_cnt_d = w_bit_end ? '0 : bit_cnt_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (load_i) begin
          state_d = ST_START_BIT;
          shift_d = byte_i;
          idx_d   = '0;
`ifdef TX_PARITY_EN
          parity_d = ^byte_i;
`endif
        end
      end
      ST_START_BIT: begin
        if (w_bit_end) state_d = ST_DATA_BITS;
      end
      ST_DATA_BITS: begin
        if (w_bit_end) begin
          // Right shift keeps the bit on the wire at shift_q[0].
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef TX_PARITY_EN
            state_d = ST_PARITY_BIT;
`else
            state_d = ST_STOP_BIT;
`endif
          end
        end
      end
`ifdef TX_PARITY_EN
      ST_PARITY_BIT: begin
        if (w_bit_end) state_d = ST_STOP_BIT;
      end
`endif
      ST_STOP_BIT: begin
        if (w_bit_end) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    tx_o    = 1'b1;
    ready_o = 1'b0;
    sent_o  = 1'b0;
    case (state_q)
      ST_IDLE:       ready_o = 1'b1;
      ST_START_BIT:  tx_o    = 1'b0;
      ST_DATA_BITS:  tx_o    = shift_q[0];
`ifdef TX_PARITY_EN
      ST_PARITY_BIT: tx_o    = parity_q;
`endif
      ST_STOP_BIT:   sent_o  = w_bit_end;
      default:       tx_o    = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/image_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : image_uart_tx
// Description : Streams an image buffer out over a UART. On start it reads
//               NUM_BYTES bytes, one at a time, from an external buffer with
//               an rd_req / rd_valid handshake of arbitrary latency, and hands
//               each byte to the serializer.
// Ports       : clk      - clock, rising edge
//               reset    - asynchronous active-high reset
//               start    - begin one image (ignored while busy)
//               rd_req   - one-cycle read strobe to the buffer
//               rd_addr  - byte address, valid with rd_req and held after
//               rd_data  - buffer read data, qualified by rd_valid
//               rd_valid - one-cycle data strobe, >= 1 cycle after rd_req
//               tx       - UART line, idle high
//               busy     - image in progress
//               done     - one-cycle pulse after the last stop bit
// Macro       : TX_PARITY_EN - adds an even-parity bit to every character.
// Revision    : 1.0 - initial release
// ============================================================================
module image_uart_tx
  import image_io_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int NUM_BYTES    = IMAGE_BYTES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        rd_req,
  output logic [15:0] rd_addr,
  input  logic [7:0]  rd_data,
  input  logic        rd_valid,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam logic [15:0] LAST_ADDR = 16'(NUM_BYTES - 1);

  // The sequencer uses ST_START_BIT as its "character on the wire" state;
  // the serializer walks the individual bit states underneath it.
  state_e      state_q, state_d;
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic        w_ser_load;
  logic        w_ser_ready;
  logic        w_ser_sent;

  uart_tx_serializer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_serializer (
    .clk     (clk),
    .reset   (reset),
    .load_i  (w_ser_load),
    .byte_i  (rd_data),
    .ready_o (w_ser_ready),
    .sent_o  (w_ser_sent),
    .tx_o    (tx)
  );

  // State and byte counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      byte_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          byte_cnt_d = '0;
          state_d    = ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_WAIT_DATA;
      ST_WAIT_DATA: begin
        if (rd_valid && w_ser_ready) state_d = ST_START_BIT;
      end
      ST_START_BIT: begin
        if (w_ser_sent) begin
          // The counter stops at the last address so rd_addr never runs
          // past the end of the buffer.
          if (byte_cnt_q < LAST_ADDR) begin
            byte_cnt_d = byte_cnt_q + 16'd1;
            state_d    = ST_FETCH;
          end else begin
            state_d    = ST_FINISH;
          end
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    rd_req     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    w_ser_load = 1'b0;
    case (state_q)
      ST_FETCH: begin
        rd_req = 1'b1;
        busy   = 1'b1;
      end
      ST_WAIT_DATA: begin
        busy       = 1'b1;
        w_ser_load = rd_valid;
      end
      ST_START_BIT: busy = 1'b1;
      ST_FINISH:    done = 1'b1;
      default:      busy = 1'b0;
    endcase
  end

  assign rd_addr = byte_cnt_q;

endmodule
`default_nettype wire

// File: doc/image_uart_tx.md
IMAGE_UART_TX -- requirements
Module: image_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 4, clock cycles per UART bit.
REQ-002 SHALL have parameter NUM_BYTES, default 784, bytes per image frame.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request to transmit one image.
REQ-006 SHALL have port rd_req  output  1  one-cycle read strobe to image buffer.
REQ-007 SHALL have port rd_addr  output  16  image buffer byte address.
REQ-008 SHALL have port rd_data  input  8  buffer read data, qualified by rd_valid.
REQ-009 SHALL have port rd_valid  input  1  rd_data valid, one cycle, any latency >= 1 after rd_req.
REQ-010 SHALL have port tx  output  1  UART serial line, idle high.
REQ-011 SHALL have port busy  output  1  high from accepted start until done.
REQ-012 SHALL have port done  output  1  one-cycle pulse after last stop bit.

Function
REQ-013 SHALL implement states IDLE, FETCH, WAIT_DATA, START_BIT, DATA_BITS, [PARITY_BIT], STOP_BIT, FINISH.
REQ-014 SHALL, in IDLE with start=1, clear byte counter and enter FETCH next cycle; busy=1 from that cycle.
REQ-015 SHALL, in FETCH, drive rd_req=1 for exactly one cycle with rd_addr=byte counter, then enter WAIT_DATA.
REQ-016 SHALL, in WAIT_DATA, latch rd_data into shift register on the rd_valid cycle and enter START_BIT next cycle; ignore rd_valid in all other states.
REQ-017 SHALL drive tx=0 for CLKS_PER_BIT cycles in START_BIT, then 8 data bits LSB first, each CLKS_PER_BIT cycles, then tx=1 for CLKS_PER_BIT cycles in STOP_BIT.
REQ-018 SHALL use a bit-period counter of width $clog2(CLKS_PER_BIT) and a 3-bit data index; no bit shorter or longer than CLKS_PER_BIT cycles.
REQ-019 SHALL, at end of STOP_BIT, increment byte counter and return to FETCH if counter < NUM_BYTES-1, else enter FINISH.
REQ-020 SHALL, in FINISH, assert done=1 for one cycle, deassert busy in the same cycle, and return to IDLE.
REQ-021 SHALL ignore start while busy=1; start held high in IDLE after FINISH begins a new frame at address 0.
REQ-022 SHALL keep tx=1 in IDLE, FETCH, WAIT_DATA and FINISH (no glitch between bytes).
REQ-023 SHALL hold rd_addr stable from FETCH until next increment; byte counter never exceeds NUM_BYTES-1.
REQ-024 SHALL wait indefinitely in WAIT_DATA if rd_valid never arrives (no timeout).

Reset
REQ-025 SHALL, on reset=1 at any time including mid-bit, immediately force tx=1, busy=0, done=0, rd_req=0, rd_addr=0, state=IDLE, all counters and shift register to 0.
REQ-026 SHALL resume normal operation only on a start sampled after reset deasserts.

Configuration
REQ-027 SHALL, with TX_PARITY_EN defined, insert PARITY_BIT between last data bit and stop bit carrying even parity (XOR of 8 data bits), CLKS_PER_BIT cycles long; frame = 11 bits.
REQ-028 SHALL, without TX_PARITY_EN, omit PARITY_BIT entirely; frame = 10 bits, 8N1.

Structure
REQ-029 SHALL place state enum type, IMAGE_BYTES=784 constant and UART frame-length constants in package image_io_pkg.
REQ-030 SHALL split bit serialization (START/DATA/PARITY/STOP timing, tx drive) into sub-module uart_tx_serializer with load/byte/ready handshake; image_uart_tx owns fetch sequencing.

Verification
REQ-031 Reset, start=1 one cycle, rd_valid 1 cycle after rd_req with rd_data=8'hA5 -> tx low 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, then high 4 cycles.
REQ-032 NUM_BYTES=3, buffer {8'h00,8'h7E,8'hFF} -> rd_addr 0,1,2 each with single rd_req; 30 bit periods total; done one pulse; busy low after.
REQ-033 Full 784-byte frame with rd_valid latency 3 -> receiver model reconstructs all 784 bytes in order; done at end; rd_addr never reaches 784.
REQ-034 reset asserted during DATA_BITS of byte 5 -> tx=1 same cycle, busy=0; subsequent start resends from rd_addr=0.
REQ-035 start pulsed repeatedly while busy -> no extra rd_req, frame length unchanged.
REQ-036 TX_PARITY_EN defined, rd_data=8'h07 -> parity bit 1 after bit 7, then stop; 8'h03 -> parity bit 0.
